// File: rtl/nand_share_if.sv
// Requester-side bus of the shared NAND arbiter: request/operand lines in,
// grant and response lines out.
interface nand_share_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic           rsp_y;
    logic           rsp_err;
    logic [7:0]     err_cnt;
    logic           busy;

    modport master (
        output req, op_a, op_b,
        input  gnt, rsp_valid, rsp_id, rsp_y, rsp_err, err_cnt, busy
    );

    modport slave (
        input  req, op_a, op_b,
        output gnt, rsp_valid, rsp_id, rsp_y, rsp_err, err_cnt, busy
    );
endinterface

// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter sharing one external NAND gate among N requesters;
// drives registered operands, waits SETTLE cycles, returns and checks gate_y.
module nand_share_arbiter #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int IDW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    nand_share_if.slave  bus,
    output logic         gate_a,
    output logic         gate_b,
    input  logic         gate_y
);
    typedef enum logic {S_IDLE, S_SETTLE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           ga_q, ga_d, gb_q, gb_d;
    logic           rv_q, rv_d, ry_q, ry_d, re_q, re_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [7:0]     ec_q, ec_d;

    logic [IDW-1:0] win;
    logic           win_vld;
    logic [IDW:0]   sum;
    logic [IDW:0]   nxt;

    // First set request bit at or above the pointer, wrapping N-1 -> 0.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N))
                sum = sum - (IDW+1)'(N);
            if (!win_vld && bus.req[sum[IDW-1:0]]) begin
                win_vld = 1'b1;
                win     = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, win} + (IDW+1)'(1);
        if (nxt == (IDW+1)'(N))
            nxt = '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        ga_d    = ga_q;
        gb_d    = gb_q;
        rv_d    = 1'b0;
        re_d    = 1'b0;
        ry_d    = ry_q;
        rid_d   = rid_q;
        ec_d    = ec_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d[win] = 1'b1;
                    ga_d       = bus.op_a[win];
                    gb_d       = bus.op_b[win];
                    id_d       = win;
                    cnt_d      = 4'(SETTLE - 1);
                    ptr_d      = nxt[IDW-1:0];
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // gate_y is only looked at on this final settle edge.
                    ry_d    = gate_y;
                    rid_d   = id_q;
                    rv_d    = 1'b1;
                    re_d    = (gate_y == (ga_q & gb_q));
                    if (re_d && ec_q != 8'hFF)
                        ec_d = ec_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ga_q    <= 1'b0;
            gb_q    <= 1'b0;
            rv_q    <= 1'b0;
            ry_q    <= 1'b0;
            re_q    <= 1'b0;
            rid_q   <= '0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            rv_q    <= rv_d;
            ry_q    <= ry_d;
            re_q    <= re_d;
            rid_q   <= rid_d;
            ec_q    <= ec_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_id    = rid_q;
    assign bus.rsp_y     = ry_q;
    assign bus.rsp_err   = re_q;
    assign bus.err_cnt   = ec_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign gate_a        = ga_q;
    assign gate_b        = gb_q;
endmodule
